rr_arb4_dec: RTL

- 4-requester round-robin arbiter for one shared resource.
- Grants are one-hot, active-low outputs, gated by an active-low global enable, following the team's 2-to-4 decode convention.
- The winner index is registered, then decoded to four active-low grant lines, so exactly one (or zero) requester owns the resource.
- Sits between up to four masters and a shared peripheral/bus segment; supports optional hold-time preemption.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/gnt_dec2_4n.sv | 17 +
 rtl/rr_arb4_dec.sv | 127 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared constants for the 4-way round-robin arbiter: FSM encodings, requester count and
// the all-released grant pattern.
package arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam int unsigned N_REQ = 4;

  localparam logic [3:0] GNT_NONE = 4'b1111;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] oh;
    oh      = 4'b0000;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/gnt_dec2_4n.sv
// Combinational 2-to-4 decoder with active-low enable and active-low outputs.
module gnt_dec2_4n
  import arb_pkg::*;
(
  input  logic [1:0] idx,
  input  logic       en_n,
  output logic [3:0] y_n
);

  always_comb begin
    y_n = GNT_NONE;
    if (!en_n) begin
      y_n[idx] = 1'b0;
    end
  end

endmodule

// File: rtl/rr_arb4_dec.sv
// Four-requester round-robin arbiter with registered active-low one-hot grants, a forced dead
// cycle between owners and optional hold-time preemption.
module rr_arb4_dec
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_n,
  input  logic [3:0] req,
  output logic [3:0] gnt_n,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       preempt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_MAX  = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]       gnt_n_q, gnt_n_d;
  logic             preempt_q, preempt_d;

  logic [1:0] start;
  logic [7:0] req2;
  logic [3:0] rot;
  logic [1:0] pe;
  logic [1:0] winner;
  logic       arb_ok;
  logic       rel, dis, pre;
  logic       dec_en_n;

  // Rotate so that last+1 sits at bit 0, pick the lowest set bit, then rotate the index back.
  always_comb begin
    start = last_q + 2'd1;
    req2  = {req, req};
    rot   = req2[start +: 4];
    pe    = 2'd0;
    for (int j = 3; j >= 0; j--) begin
      if (rot[j]) begin
        pe = 2'(j);
      end
    end
    winner = start + pe;
    arb_ok = !en_n && (req != 4'b0000);
  end

  always_comb begin
    rel = !req[idx_q];
    dis = en_n;
    pre = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) &&
          ((req & ~onehot4(idx_q)) != 4'b0000);
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;
    unique case (state_q)
      ST_GRANT: begin
        if (rel || dis || pre) begin
          state_d   = ST_GAP;
          last_d    = idx_q;
          // Release and disable win over the hold limit, so they never report a preemption.
          preempt_d = pre && !rel && !dis;
        end else if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (arb_ok) begin
          state_d    = ST_GRANT;
          idx_d      = winner;
          hold_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (arb_ok) begin
          state_d    = ST_GRANT;
          idx_d      = winner;
          hold_cnt_d = '0;
        end
      end
    endcase
  end

  assign dec_en_n = (state_d != ST_GRANT);

  gnt_dec2_4n u_dec (
    .idx  (idx_d),
    .en_n (dec_en_n),
    .y_n  (gnt_n_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_q     <= 2'd3;
      idx_q      <= 2'd0;
      hold_cnt_q <= '0;
      gnt_n_q    <= GNT_NONE;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_n_q    <= gnt_n_d;
      preempt_q  <= preempt_d;
    end
  end

  assign gnt_n   = gnt_n_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = ~&gnt_n_q;
  assign preempt = preempt_q;

endmodule
